// File: rtl/edge_event_arbiter.sv
// Multi-channel edge-event controller.
// Each level input is edge-detected; rising and falling edges are latched as
// pending bits per channel, and a round-robin arbiter serialises the pending
// channels onto a single registered valid/ready event slot. Lost edges (an
// edge arriving while the same kind is still pending) raise a sticky flag.
module edge_event_arbiter #(
    parameter int N_CH = 4,
    parameter int IDW  = $clog2(N_CH)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] a_i,
    input  logic [N_CH-1:0] en_i,
    output logic            evt_valid_o,
    input  logic            evt_ready_i,
    output logic [IDW-1:0]  evt_id_o,
    output logic            evt_rise_o,
    output logic            evt_fall_o,
    output logic [N_CH-1:0] overflow_o
);

    // Input history and per-channel pending/overflow state
    logic [N_CH-1:0] a_q;
    logic [N_CH-1:0] rise_pend_q;
    logic [N_CH-1:0] rise_pend_d;
    logic [N_CH-1:0] fall_pend_q;
    logic [N_CH-1:0] fall_pend_d;
    logic [N_CH-1:0] overflow_q;
    logic [N_CH-1:0] overflow_d;

    // Per-channel combinational helpers
    logic [N_CH-1:0] rise_det;
    logic [N_CH-1:0] fall_det;
    logic [N_CH-1:0] retire_ch;
    logic [N_CH-1:0] retire_rise;
    logic [N_CH-1:0] retire_fall;
    logic [N_CH-1:0] cand;

    // Output slot registers
    logic            valid_q;
    logic            valid_d;
    logic [IDW-1:0]  id_q;
    logic [IDW-1:0]  id_d;
    logic            rise_q;
    logic            rise_d;
    logic            fall_q;
    logic            fall_d;

    // Round-robin pointer: index searched first on the next load
    logic [IDW-1:0]  rr_ptr_q;
    logic [IDW-1:0]  rr_ptr_d;

    // Arbiter result
    logic            win_found;
    logic [IDW-1:0]  win_id;

    logic            handshake;
    logic            slot_free;

    assign handshake = valid_q & evt_ready_i;
    // The slot can take a new event when empty or when its current event
    // leaves this very cycle, giving back-to-back issue with ready held high.
    assign slot_free = ~valid_q | handshake;

    // Per-channel edge detection, retire decode and pending bookkeeping.
    // Pending bits set by a new edge win over a same-cycle retire, so an edge
    // that lands while its channel is being reported is never dropped.
    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            assign rise_det[gi] = a_i[gi] & ~a_q[gi] & en_i[gi];
            assign fall_det[gi] = ~a_i[gi] & a_q[gi] & en_i[gi];

            assign retire_ch[gi]   = handshake & (id_q == IDW'(gi));
            assign retire_rise[gi] = retire_ch[gi] & rise_q;
            assign retire_fall[gi] = retire_ch[gi] & fall_q;

            assign rise_pend_d[gi] = rise_det[gi] | (rise_pend_q[gi] & ~retire_rise[gi]);
            assign fall_pend_d[gi] = fall_det[gi] | (fall_pend_q[gi] & ~retire_fall[gi]);

            // An edge is lost only when the same kind is still pending and
            // is not being handed off to the consumer in this cycle.
            assign overflow_d[gi] = overflow_q[gi]
                                  | (rise_det[gi] & rise_pend_q[gi] & ~retire_rise[gi])
                                  | (fall_det[gi] & fall_pend_q[gi] & ~retire_fall[gi]);

            // The retiring channel is excluded so it cannot be re-presented
            // with stale bits; edges from this cycle wait until next cycle.
            assign cand[gi] = (rise_pend_q[gi] | fall_pend_q[gi]) & ~retire_ch[gi];
        end
    endgenerate

    // Round-robin search starting at rr_ptr and wrapping modulo N_CH
    always_comb begin
        int idx;
        win_found = 1'b0;
        win_id    = '0;
        idx       = 0;
        for (int k = 0; k < N_CH; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= N_CH) begin
                idx = idx - N_CH;
            end
            if (!win_found && cand[idx]) begin
                win_found = 1'b1;
                win_id    = IDW'(idx);
            end
        end
    end

    // Slot next-state: hold while stalled, otherwise load the winner or empty
    always_comb begin
        valid_d  = valid_q;
        id_d     = id_q;
        rise_d   = rise_q;
        fall_d   = fall_q;
        rr_ptr_d = rr_ptr_q;
        if (slot_free) begin
            if (win_found) begin
                valid_d = 1'b1;
                id_d    = win_id;
                rise_d  = rise_pend_q[win_id];
                fall_d  = fall_pend_q[win_id];
                if (win_id == IDW'(N_CH - 1)) begin
                    rr_ptr_d = '0;
                end else begin
                    rr_ptr_d = win_id + 1'b1;
                end
            end else begin
                valid_d = 1'b0;
            end
        end
    end

    // State registers with synchronous reset taking priority
    always_ff @(posedge clk) begin
        if (reset) begin
            a_q         <= '0;
            rise_pend_q <= '0;
            fall_pend_q <= '0;
            overflow_q  <= '0;
            valid_q     <= 1'b0;
            id_q        <= '0;
            rise_q      <= 1'b0;
            fall_q      <= 1'b0;
            rr_ptr_q    <= '0;
        end else begin
            a_q         <= a_i;
            rise_pend_q <= rise_pend_d;
            fall_pend_q <= fall_pend_d;
            overflow_q  <= overflow_d;
            valid_q     <= valid_d;
            id_q        <= id_d;
            rise_q      <= rise_d;
            fall_q      <= fall_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign evt_valid_o = valid_q;
    assign evt_id_o    = id_q;
    assign evt_rise_o  = rise_q;
    assign evt_fall_o  = fall_q;
    assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed testbench for edge_event_arbiter: hand-computed event sequences
// covering latency, backpressure, round-robin order, merged edges, overflow,
// channel enable and reset in flight.
module tb_edge_event_arbiter;

    logic       clk;
    logic       reset;
    logic [3:0] a_i;
    logic [3:0] en_i;
    logic       evt_valid_o;
    logic       evt_ready_i;
    logic [1:0] evt_id_o;
    logic       evt_rise_o;
    logic       evt_fall_o;
    logic [3:0] overflow_o;

    int checks;
    int failures;

    edge_event_arbiter #(.N_CH(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .a_i         (a_i),
        .en_i        (en_i),
        .evt_valid_o (evt_valid_o),
        .evt_ready_i (evt_ready_i),
        .evt_id_o    (evt_id_o),
        .evt_rise_o  (evt_rise_o),
        .evt_fall_o  (evt_fall_o),
        .overflow_o  (overflow_o)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_idle(input string tag);
        check_val({tag, "_valid"}, 32'(evt_valid_o), 32'd0);
    endtask

    task automatic expect_evt(input string tag, input int id, input int r, input int f);
        check_val({tag, "_valid"}, 32'(evt_valid_o), 32'd1);
        check_val({tag, "_id"},    32'(evt_id_o),    32'(id));
        check_val({tag, "_rise"},  32'(evt_rise_o),  32'(r));
        check_val({tag, "_fall"},  32'(evt_fall_o),  32'(f));
        $display("evt %s id=%0d rise=%0d fall=%0d", tag, evt_id_o, evt_rise_o, evt_fall_o);
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        clk         = 1'b0;
        reset       = 1'b1;
        a_i         = 4'b0001;
        en_i        = 4'b1111;
        evt_ready_i = 1'b1;

        // 1: reset state, then ch0 held high yields a rise two edges later
        tick();
        tick();
        check_val("rst_valid", 32'(evt_valid_o), 32'd0);
        check_val("rst_id",    32'(evt_id_o),    32'd0);
        check_val("rst_rise",  32'(evt_rise_o),  32'd0);
        check_val("rst_fall",  32'(evt_fall_o),  32'd0);
        check_val("rst_ovf",   32'(overflow_o),  32'd0);
        reset = 1'b0;
        tick();
        expect_idle("t1_lat");
        tick();
        expect_evt("t1_evt", 0, 1, 0);
        check_val("t1_ovf", 32'(overflow_o), 32'd0);
        tick();
        expect_idle("t1_done");

        // 2: backpressure holds ch2 event stable, one handshake then empty
        evt_ready_i = 1'b0;
        a_i = 4'b0101;
        tick();
        expect_idle("t2_lat");
        tick();
        expect_evt("t2_load", 2, 1, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            expect_evt("t2_hold", 2, 1, 0);
        end
        evt_ready_i = 1'b1;
        tick();
        expect_idle("t2_done");

        // 3: re-reset to put rr_ptr at 0, then all four rise together
        reset = 1'b1;
        a_i = 4'b0000;
        tick();
        tick();
        reset = 1'b0;
        tick();
        expect_idle("t3_quiet");
        a_i = 4'b1111;
        tick();
        expect_idle("t3_lat");
        for (int i = 0; i < 4; i++) begin
            tick();
            expect_evt("t3_rise", i, 1, 0);
        end
        tick();
        expect_idle("t3_rdone");
        a_i = 4'b0000;
        tick();
        expect_idle("t3_flat");
        for (int i = 0; i < 4; i++) begin
            tick();
            expect_evt("t3_fall", i, 0, 1);
        end
        tick();
        expect_idle("t3_fdone");
        a_i = 4'b1010;
        tick();
        expect_idle("t3_plat");
        tick();
        expect_evt("t3_pair1", 1, 1, 0);
        tick();
        expect_evt("t3_pair3", 3, 1, 0);
        tick();
        expect_idle("t3_pdone");

        // 4: ch0 rise and ch3 fall compete (rr_ptr=0 picks ch0); ch2 pulses
        //    while ch0 is stalled and merges into one rise+fall event
        evt_ready_i = 1'b0;
        a_i = 4'b0011;
        tick();
        expect_idle("t4_lat");
        a_i = 4'b0111;
        tick();
        expect_evt("t4_ch0", 0, 1, 0);
        a_i = 4'b0011;
        tick();
        expect_evt("t4_ch0_hold", 0, 1, 0);
        evt_ready_i = 1'b1;
        tick();
        expect_evt("t4_ch2", 2, 1, 1);
        tick();
        expect_evt("t4_ch3", 3, 0, 1);
        tick();
        expect_idle("t4_done");
        check_val("t4_ovf", 32'(overflow_o), 32'd0);

        // 5: ch1 falls (drained), then rises, falls, rises before consumption;
        //    ch3 toggles with its enable off
        a_i = 4'b0001;
        tick();
        expect_idle("t5_pre_lat");
        tick();
        expect_evt("t5_pre", 1, 0, 1);
        tick();
        expect_idle("t5_pre_done");
        en_i = 4'b0111;
        evt_ready_i = 1'b0;
        a_i = 4'b1011;
        tick();
        expect_idle("t5_lat");
        a_i = 4'b0001;
        tick();
        expect_evt("t5_load", 1, 1, 0);
        a_i = 4'b1011;
        tick();
        expect_evt("t5_hold", 1, 1, 0);
        check_val("t5_ovf_set", 32'(overflow_o), 32'h2);
        evt_ready_i = 1'b1;
        tick();
        expect_idle("t5_gap");
        check_val("t5_ovf_keep", 32'(overflow_o), 32'h2);
        tick();
        expect_evt("t5_fall", 1, 0, 1);
        tick();
        expect_idle("t5_no_ch3a");
        check_val("t5_ovf_sticky", 32'(overflow_o), 32'h2);
        tick();
        expect_idle("t5_no_ch3b");

        // 6: drain falls (rr_ptr=2), present a rise with others pending,
        //    reset mid-flight, then held-high inputs re-report as rises
        en_i = 4'b1111;
        a_i = 4'b0000;
        tick();
        expect_idle("t6_lat");
        tick();
        expect_evt("t6_f3", 3, 0, 1);
        tick();
        expect_evt("t6_f0", 0, 0, 1);
        tick();
        expect_evt("t6_f1", 1, 0, 1);
        tick();
        expect_idle("t6_drained");
        evt_ready_i = 1'b0;
        a_i = 4'b0111;
        tick();
        expect_idle("t6_rlat");
        tick();
        expect_evt("t6_pres", 2, 1, 0);
        reset = 1'b1;
        tick();
        check_val("t6_rst_valid", 32'(evt_valid_o), 32'd0);
        check_val("t6_rst_id",    32'(evt_id_o),    32'd0);
        check_val("t6_rst_rise",  32'(evt_rise_o),  32'd0);
        check_val("t6_rst_fall",  32'(evt_fall_o),  32'd0);
        check_val("t6_rst_ovf",   32'(overflow_o),  32'd0);
        reset = 1'b0;
        evt_ready_i = 1'b1;
        tick();
        expect_idle("t6_post_lat");
        tick();
        expect_evt("t6_r0", 0, 1, 0);
        tick();
        expect_evt("t6_r1", 1, 1, 0);
        tick();
        expect_evt("t6_r2", 2, 1, 0);
        tick();
        expect_idle("t6_done");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/edge_event_arbiter.md
Name: edge_event_arbiter

Overview:
- Multi-channel edge-event controller built around per-channel rise/fall edge detectors.
- Each of N_CH inputs is edge-detected and its edges are latched as pending events.
- One round-robin arbiter serialises the pending events onto a single valid/ready event port.
- Sits between raw level inputs (buttons, status lines) and one downstream consumer that handles one event per handshake.

Parameters:
- N_CH, 4, number of input channels (≥2).
- IDW, $clog2(N_CH), width of the channel-id output (derived; do not override).

Ports:
- clk  input  1  system clock, all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- a_i  input  N_CH  level inputs, one per channel, synchronous to clk.
- en_i  input  N_CH  per-channel enable; 0 = new edges on that channel are ignored.
- evt_valid_o  output  1  event presented.
- evt_ready_i  input  1  consumer accepts the event when evt_valid_o && evt_ready_i.
- evt_id_o  output  IDW  channel index of the presented event.
- evt_rise_o  output  1  a rising edge occurred on evt_id_o since its last report.
- evt_fall_o  output  1  a falling edge occurred on evt_id_o since its last report.
- overflow_o  output  N_CH  sticky per-channel lost-edge flag.

Behaviour:
- Reset (synchronous, active-high): a_q, rise_pend, fall_pend, overflow_o, evt_valid_o, evt_id_o, evt_rise_o, evt_fall_o and rr_ptr all go to 0. Reset has priority over every other event.
- Edge detect per channel i:
  - a_q[i] <= a_i[i] every cycle.
  - rise[i] = a_i & ~a_q & en_i.
  - fall[i] = ~a_i & a_q & en_i.
  - a_q resets to 0, so an input held at 1 across reset release yields a rising edge on the first non-reset cycle.
- Pending:
  - rise_pend[i] is set on rise[i] and cleared when channel i's event completes a handshake. Set wins over clear in the same cycle; fall_pend is identical.
  - Clearing en_i does not clear existing pending bits.
- Overflow:
  - overflow_o[i] <= 1 when rise[i] arrives while rise_pend[i]=1 and that bit is not being cleared this cycle. The same rule applies to fall.
  - Only reset clears it.
- Output slot: a registered skid-free slot.
  - Slot is "free" when evt_valid_o=0 or a handshake occurs this cycle.
  - When free, it loads the round-robin winner among channels with (rise_pend|fall_pend)=1.
  - The channel being retired this cycle is excluded from the candidate mask. Edges detected this cycle are not yet candidates.
  - Loaded values: evt_id_o=winner, evt_rise_o=rise_pend[w], evt_fall_o=fall_pend[w], evt_valid_o=1.
  - If there is no candidate, evt_valid_o<=0.
- Stability: while evt_valid_o && !evt_ready_i, all evt_* outputs hold stable. Edges arriving on the presented channel stay in pend and are reported in a later event.
- Retire: on handshake, clear rise_pend[id] if evt_rise_o, and fall_pend[id] if evt_fall_o. New same-cycle edges re-set the bit (set wins).
- Round-robin:
  - rr_ptr is the highest-priority index; search is rr_ptr, rr_ptr+1, …, wrapping mod N_CH.
  - On each load, rr_ptr <= winner+1 (mod N_CH).
- Latency:
  - An edge sampled at posedge T sets pend at T.
  - The event is loaded at T+1 if the slot is free, so evt_valid_o is high after T+1 (2-edge latency).
  - With evt_ready_i held at 1, events issue back-to-back, one per cycle.
- Both bits set: a rise and a fall on one channel before it is reported give a single event with rise=fall=1. No ordering information is kept.

Test Plan:
1. Reset with a_i=0001, en_i=1111, ready=1; release reset -> two edges later evt_valid_o=1, id=0, rise=1, fall=0 for one cycle; overflow_o=0000.
2. Backpressure: ready=0 with ch2 rising -> id=2, rise=1 held stable for 5 cycles; raise ready -> one handshake, then valid=0.
3. ch0..3 rise in the same cycle, ready=1, rr_ptr=0 -> ids 0,1,2,3 on 4 consecutive cycles. Then ch1 and ch3 rise together (rr_ptr=0) -> ids 1,3, and rr_ptr ends at 0.
4. ready=0 with ch0 presented; ch2 toggles 0->1->0 -> after ch0 retires, a single event id=2, rise=1, fall=1; overflow_o[2]=0.
5. ready=0; ch1 rises, falls, rises again before report -> overflow_o[1]=1 and stays 1 after the event is consumed. en_i[3]=0 with ch3 toggling -> no ch3 event.
6. Reset asserted while valid=1 and 3 channels pending -> after next edge all outputs 0. After release, a_i still high on those channels -> rising events again (a_q=0 after reset).
